// File: rtl/vector_mem_sequencer_if.sv
// vector_mem_sequencer_if: bundles the datapath-side request/response signals and the
// data-cache-side access signals of vector_mem_sequencer.
//   slave  modport : the sequencer's view (serves datapath requests, drives cache strobes)
//   master modport : the environment's view (datapath + data cache)
// Optional feature macro: VMS_LANE_MASK_EN adds the per-lane mask input vmask.
interface vector_mem_sequencer_if #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned WORD_W  = 32
);
  // Datapath side
  logic                            readReq;
  logic                            writeReq;
  logic                            isVector;
  logic                            dhalt;
  logic [THREADS-1:0][WORD_W-1:0]  vdaddr;
  logic [THREADS-1:0][WORD_W-1:0]  vdstore;
  logic [WORD_W-1:0]               sdaddr;
  logic [WORD_W-1:0]               sdstore;
  logic                            dHit;
  logic [THREADS-1:0][WORD_W-1:0]  vdload;
  logic [WORD_W-1:0]               sdload;
`ifdef VMS_LANE_MASK_EN
  logic [THREADS-1:0]              vmask;
`endif
  // Data cache side
  logic                            dmemREN;
  logic                            dmemWEN;
  logic [WORD_W-1:0]               dmemaddr;
  logic [WORD_W-1:0]               dmemstore;
  logic [WORD_W-1:0]               dmemload;
  logic                            dcacheHit;
  logic                            chalt;

  modport slave (
`ifdef VMS_LANE_MASK_EN
    input  vmask,
`endif
    input  readReq, writeReq, isVector, dhalt, vdaddr, vdstore, sdaddr, sdstore,
    input  dmemload, dcacheHit,
    output dHit, vdload, sdload, dmemREN, dmemWEN, dmemaddr, dmemstore, chalt
  );

  modport master (
`ifdef VMS_LANE_MASK_EN
    output vmask,
`endif
    output readReq, writeReq, isVector, dhalt, vdaddr, vdstore, sdaddr, sdstore,
    output dmemload, dcacheHit,
    input  dHit, vdload, sdload, dmemREN, dmemWEN, dmemaddr, dmemstore, chalt
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: serializes scalar/vector datapath memory requests into single-word
// data-cache accesses (one per lane, in lane order for vectors) and gathers load data back
// into per-lane registers. dHit pulses once when the whole request is complete.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - vector_mem_sequencer_if.slave: datapath request/response and cache access signals
// Optional feature macro: VMS_LANE_MASK_EN (per-lane mask vmask; zero-mask lanes are skipped).
module vector_mem_sequencer #(
  parameter int unsigned THREADS = 4,
  parameter int unsigned WORD_W  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  vector_mem_sequencer_if.slave bus
);
  localparam int unsigned IdxW = $clog2(THREADS);

  typedef logic [WORD_W-1:0]              word_t;
  typedef logic [THREADS-1:0][WORD_W-1:0] lanes_t;
  typedef enum logic [1:0] {StIdle, StAccess, StDone, StHalt} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            wr_q, wr_d;
  logic            vec_q, vec_d;
  lanes_t          vaddr_q, vaddr_d;
  lanes_t          vstore_q, vstore_d;
  lanes_t          vdload_q, vdload_d;
  word_t           saddr_q, saddr_d;
  word_t           sstore_q, sstore_d;
  word_t           sdload_q, sdload_d;
  logic            last_access;
  logic            in_access;

`ifdef VMS_LANE_MASK_EN
  logic [THREADS-1:0] mask_q, mask_d;
  logic               first_any, next_any;
  logic [IdxW-1:0]    first_idx, next_idx;

  // Lowest set bit of the incoming mask, and lowest set bit of the latched mask above idx.
  always_comb begin
    first_any = 1'b0;
    first_idx = '0;
    next_any  = 1'b0;
    next_idx  = '0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (bus.vmask[i]) begin
        first_any = 1'b1;
        first_idx = IdxW'(i);
      end
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_any = 1'b1;
        next_idx = IdxW'(i);
      end
    end
  end

  assign last_access = !vec_q || !next_any;
`else
  assign last_access = !vec_q || (idx_q == IdxW'(THREADS - 1));
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    vec_d    = vec_q;
    vaddr_d  = vaddr_q;
    vstore_d = vstore_q;
    vdload_d = vdload_q;
    saddr_d  = saddr_q;
    sstore_d = sstore_q;
    sdload_d = sdload_q;
`ifdef VMS_LANE_MASK_EN
    mask_d   = mask_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.readReq || bus.writeReq) begin
          wr_d     = bus.writeReq;  // both lines high resolves to a write
          vec_d    = bus.isVector;
          vaddr_d  = bus.vdaddr;
          vstore_d = bus.vdstore;
          saddr_d  = bus.sdaddr;
          sstore_d = bus.sdstore;
          idx_d    = '0;
          state_d  = StAccess;
`ifdef VMS_LANE_MASK_EN
          mask_d = bus.vmask;
          if (bus.isVector) begin
            if (first_any) idx_d = first_idx;
            else           state_d = StDone;
          end
`endif
        end else if (bus.dhalt) begin
          state_d = StHalt;
        end
      end
      StAccess: begin
        if (bus.dcacheHit) begin
          if (!wr_q) begin
            if (vec_q) vdload_d[idx_q] = bus.dmemload;
            else       sdload_d        = bus.dmemload;
          end
          if (last_access) begin
            state_d = StDone;
          end else begin
`ifdef VMS_LANE_MASK_EN
            idx_d = next_idx;
`else
            idx_d = idx_q + 1'b1;
`endif
          end
        end
      end
      // A halt raised while the request was in flight is taken right after completion.
      StDone:  state_d = bus.dhalt ? StHalt : StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      vec_q    <= 1'b0;
      vaddr_q  <= '0;
      vstore_q <= '0;
      vdload_q <= '0;
      saddr_q  <= '0;
      sstore_q <= '0;
      sdload_q <= '0;
`ifdef VMS_LANE_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      vec_q    <= vec_d;
      vaddr_q  <= vaddr_d;
      vstore_q <= vstore_d;
      vdload_q <= vdload_d;
      saddr_q  <= saddr_d;
      sstore_q <= sstore_d;
      sdload_q <= sdload_d;
`ifdef VMS_LANE_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  // Cache-side outputs decode registered state only; zero outside ACCESS.
  assign in_access     = (state_q == StAccess);
  assign bus.dmemREN   = in_access && !wr_q;
  assign bus.dmemWEN   = in_access && wr_q;
  assign bus.dmemaddr  = in_access ? (vec_q ? vaddr_q[idx_q] : saddr_q) : '0;
  assign bus.dmemstore = in_access ? (vec_q ? vstore_q[idx_q] : sstore_q) : '0;
  assign bus.dHit      = (state_q == StDone);
  assign bus.chalt     = (state_q == StHalt);
  assign bus.vdload    = vdload_q;
  assign bus.sdload    = sdload_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: a bench-side cache model answers strobes,
// expected accesses are queued when a request is driven and popped as the DUT issues them.
module tb_vector_mem_sequencer;
  localparam int unsigned THREADS = 4;
  localparam int unsigned WORD_W  = 32;

  typedef struct {
    logic        we;
    logic [2:0]  lane;  // 4 = scalar
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_mem_sequencer_if #(.THREADS(THREADS), .WORD_W(WORD_W)) bus ();

  vector_mem_sequencer #(.THREADS(THREADS), .WORD_W(WORD_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  acc_t        exp_q[$];
  logic [31:0] exp_vd[THREADS];
  logic [31:0] exp_sd;
  int          stall_lane[5];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one request from the current bus contents and plays the cache, checking every
  // strobe cycle against the expected access queue and the completion cycle.
  task automatic run_request(input string name, input bit we, input bit both, input bit vec,
                             input int exp_cycle, input int halt_cycle, input int alter_cycle);
    acc_t a;
    int   wait_cnt;
    bit   seen;
    @(negedge clk);
    if (!vec) begin
      a.we = we; a.lane = 3'd4; a.addr = bus.sdaddr; a.data = bus.sdstore;
      exp_q.push_back(a);
    end else begin
      for (int l = 0; l < THREADS; l++) begin
`ifdef VMS_LANE_MASK_EN
        if (!bus.vmask[l]) continue;
`endif
        a.we = we; a.lane = 3'(l); a.addr = bus.vdaddr[l]; a.data = bus.vdstore[l];
        exp_q.push_back(a);
      end
    end
    bus.readReq  = !we || both;
    bus.writeReq = we;
    bus.isVector = vec;
    @(posedge clk);
    wait_cnt = 0;
    seen     = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      bus.dcacheHit = 1'b0;
      if (c == halt_cycle) bus.dhalt = 1'b1;
      if (c == alter_cycle) for (int l = 0; l < THREADS; l++) bus.vdaddr[l] = ~bus.vdaddr[l];
      if (bus.dHit) begin
        seen = 1'b1;
        bus.readReq  = 1'b0;
        bus.writeReq = 1'b0;
        n_checks++;
        if (c != exp_cycle) begin
          n_fail++;
          $display("FAIL %s dhit_cycle: got %0d want %0d", name, c, exp_cycle);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL %s missing_accesses: got %0d left want 0", name, exp_q.size());
        end
        n_checks++;
        if ({bus.dmemREN, bus.dmemWEN} !== 2'b00) begin
          n_fail++;
          $display("FAIL %s strobes_at_dhit: got %b want 00", name, {bus.dmemREN, bus.dmemWEN});
        end
        n_checks++;
        if (bus.sdload !== exp_sd) begin
          n_fail++;
          $display("FAIL %s sdload: got %h want %h", name, bus.sdload, exp_sd);
        end
        for (int l = 0; l < THREADS; l++) begin
          n_checks++;
          if (bus.vdload[l] !== exp_vd[l]) begin
            n_fail++;
            $display("FAIL %s vdload[%0d]: got %h want %h", name, l, bus.vdload[l], exp_vd[l]);
          end
        end
      end else if (bus.dmemREN || bus.dmemWEN) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_access: got addr %h want none", name, bus.dmemaddr);
        end else begin
          a = exp_q[0];
          n_checks++;
          if ({bus.dmemREN, bus.dmemWEN} !== {!a.we, a.we}) begin
            n_fail++;
            $display("FAIL %s strobes: got %b want %b", name, {bus.dmemREN, bus.dmemWEN},
                     {!a.we, a.we});
          end
          n_checks++;
          if (bus.dmemaddr !== a.addr) begin
            n_fail++;
            $display("FAIL %s dmemaddr: got %h want %h", name, bus.dmemaddr, a.addr);
          end
          if (a.we) begin
            n_checks++;
            if (bus.dmemstore !== a.data) begin
              n_fail++;
              $display("FAIL %s dmemstore: got %h want %h", name, bus.dmemstore, a.data);
            end
          end
          if (wait_cnt < stall_lane[a.lane]) begin
            wait_cnt++;
          end else begin
            bus.dcacheHit = 1'b1;
            bus.dmemload  = mem_data(a.addr);
            if (!a.we) begin
              if (a.lane == 3'd4) exp_sd = mem_data(a.addr);
              else                exp_vd[a.lane] = mem_data(a.addr);
            end
            void'(exp_q.pop_front());
            wait_cnt = 0;
          end
        end
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL %s idle_gap: cycle %0d got no strobe and no dHit", name, c);
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no dHit want cycle %0d", name, exp_cycle);
    end
    exp_q.delete();
    bus.readReq   = 1'b0;
    bus.writeReq  = 1'b0;
    bus.dcacheHit = 1'b0;
  endtask

  task automatic set_lanes(input logic [31:0] base, input logic [31:0] dbase);
    for (int l = 0; l < THREADS; l++) begin
      bus.vdaddr[l]  = base + 32'(4 * l);
      bus.vdstore[l] = dbase + 32'(l);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({bus.dHit, bus.dmemREN, bus.dmemWEN, bus.chalt} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s flags: got %b want 0000", name,
               {bus.dHit, bus.dmemREN, bus.dmemWEN, bus.chalt});
    end
    n_checks++;
    if ({bus.dmemaddr, bus.dmemstore} !== 64'h0) begin
      n_fail++;
      $display("FAIL %s addr_store: got %h/%h want 0/0", name, bus.dmemaddr, bus.dmemstore);
    end
    n_checks++;
    if ({bus.vdload, bus.sdload} !== '0) begin
      n_fail++;
      $display("FAIL %s loads: got %h/%h want 0", name, bus.vdload, bus.sdload);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.readReq = 1'b0; bus.writeReq = 1'b0; bus.isVector = 1'b0; bus.dhalt = 1'b0;
    bus.sdaddr = '0; bus.sdstore = '0; bus.dmemload = '0; bus.dcacheHit = 1'b0;
    set_lanes(32'h0, 32'h0);
`ifdef VMS_LANE_MASK_EN
    bus.vmask = '1;
`endif
    for (int i = 0; i < 5; i++) stall_lane[i] = 0;
    for (int l = 0; l < THREADS; l++) exp_vd[l] = '0;
    exp_sd = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_scalar();
    bus.sdaddr = 32'h40;
    run_request("scalar_load", 1'b0, 1'b0, 1'b0, 2, 0, 0);
    bus.sdaddr = 32'h80; bus.sdstore = 32'h1234_5678;
    run_request("scalar_store", 1'b1, 1'b0, 1'b0, 2, 0, 0);
    bus.sdaddr = 32'h84; bus.sdstore = 32'hCAFE_F00D;
    run_request("both_req_is_write", 1'b1, 1'b1, 1'b0, 2, 0, 0);
  endtask

  task automatic test_vector_store();
    set_lanes(32'h100, 32'h1);
    run_request("vector_store", 1'b1, 1'b0, 1'b1, THREADS + 1, 0, 0);
  endtask

  task automatic test_vector_load_miss();
    set_lanes(32'h200, 32'h0);
    stall_lane[2] = 2;
    run_request("vector_load_miss", 1'b0, 1'b0, 1'b1, THREADS + 3, 0, 0);
    stall_lane[2] = 0;
  endtask

  task automatic test_addr_change();
    set_lanes(32'h300, 32'h0);
    run_request("addr_change", 1'b0, 1'b0, 1'b1, THREADS + 1, 0, 2);
  endtask

  task automatic test_back_to_back();
    bus.sdaddr = 32'h500;
    run_request("b2b_scalar", 1'b0, 1'b0, 1'b0, 2, 0, 0);
    set_lanes(32'h600, 32'h0);
    stall_lane[4] = 1;
    run_request("b2b_vector", 1'b0, 1'b0, 1'b1, THREADS + 1, 0, 0);
    bus.sdaddr = 32'h700;
    run_request("b2b_scalar_stall", 1'b0, 1'b0, 1'b0, 3, 0, 0);
    stall_lane[4] = 0;
  endtask

`ifdef VMS_LANE_MASK_EN
  task automatic test_lane_mask();
    set_lanes(32'h800, 32'h0);
    bus.vmask = 4'b1010;
    run_request("mask_1010", 1'b0, 1'b0, 1'b1, 3, 0, 0);
    bus.vmask = 4'b0000;
    run_request("mask_zero", 1'b0, 1'b0, 1'b1, 1, 0, 0);
    bus.sdaddr = 32'h900;
    run_request("mask_scalar", 1'b0, 1'b0, 1'b0, 2, 0, 0);
    bus.vmask = '1;
  endtask
`endif

  task automatic test_reset_mid_access();
    set_lanes(32'hA00, 32'h0);
    @(negedge clk);
    bus.readReq = 1'b1; bus.isVector = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.dmemREN !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got dmemREN=%b want 1", bus.dmemREN);
    end
    #1;
    rst = 1'b1;
    bus.readReq = 1'b0;
    #1;
    n_checks++;
    if ({bus.dmemREN, bus.dmemWEN, bus.dmemaddr} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b%b addr %h want all 0",
               bus.dmemREN, bus.dmemWEN, bus.dmemaddr);
    end
    for (int l = 0; l < THREADS; l++) exp_vd[l] = '0;
    exp_sd = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset_after");
  endtask

  task automatic test_halt();
    set_lanes(32'hB00, 32'h0);
    run_request("halt_vector", 1'b0, 1'b0, 1'b1, THREADS + 1, 2, 0);
    bus.readReq = 1'b1;  // must be ignored once halted
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.chalt, bus.dmemREN, bus.dmemWEN, bus.dHit} !== 4'b1000) begin
        n_fail++;
        $display("FAIL halt_sticky[%0d]: got chalt/ren/wen/dhit=%b want 1000", i,
                 {bus.chalt, bus.dmemREN, bus.dmemWEN, bus.dHit});
      end
    end
    bus.readReq = 1'b0;
    bus.dhalt   = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.chalt !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: got chalt=%b want 0", bus.chalt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vector_store();
    test_vector_load_miss();
    test_addr_change();
    test_back_to_back();
`ifdef VMS_LANE_MASK_EN
    test_lane_mask();
`endif
    test_reset_mid_access();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Serializes datapath memory requests into single-word data-cache accesses. A scalar request becomes one access. A vector request becomes one access per thread lane, in lane order. Load data is gathered back into per-lane registers, and a single `dHit` is raised when the whole request is complete. The block sits between the SIMT datapath's memory stage and the data cache. It owns the data-side signals of the load/store path; the instruction-side signals pass through elsewhere.

## Interface

Parameters:
- `THREADS`, 4, number of vector lanes (power of two, ≥ 2)
- `WORD_W`, 32, data and address width (word_t)

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1  system clock, rising edge
- `RST`  in  1  asynchronous active-high reset
- `readReq`  in  1  load request, held high until `dHit`
- `writeReq`  in  1  store request, held high until `dHit`
- `isVector`  in  1  1 = vector (all lanes), 0 = scalar
- `dhalt`  in  1  datapath halted; request cache flush
- `vdaddr`  in  THREADS×WORD_W  per-lane addresses
- `vdstore`  in  THREADS×WORD_W  per-lane store data
- `sdaddr`  in  WORD_W  scalar address
- `sdstore`  in  WORD_W  scalar store data
- `dHit`  out  1  one-cycle pulse: request complete
- `vdload`  out  THREADS×WORD_W  per-lane gathered load data (registered)
- `sdload`  out  WORD_W  scalar load data (registered)
- `dmemREN`  out  1  cache read strobe
- `dmemWEN`  out  1  cache write strobe
- `dmemaddr`  out  WORD_W  cache address
- `dmemstore`  out  WORD_W  cache store data
- `dmemload`  in  WORD_W  cache read data, valid with `dcacheHit`
- `dcacheHit`  in  1  cache completed the current access this cycle
- `chalt`  out  1  flush/halt request to cache, sticky

## Operation

- FSM states: IDLE, ACCESS, DONE, HALT.
- **IDLE**
  - `readReq|writeReq` high: latch op, `isVector`, all addresses and store data into internal registers; set lane index `idx=0`; go to ACCESS.
  - If both request lines are high, the request is treated as a write.
  - No request and `dhalt` high: go to HALT.
- **ACCESS**
  - Drive `dmemREN` (load) or `dmemWEN` (store) from the latched op, never both.
  - Address and data come from the latched registers: lane `idx` for vector, scalar registers for scalar.
  - On `dcacheHit`:
    - for a load, write `dmemload` into `vdload[idx]` (vector) or `sdload` (scalar);
    - if this is the last access, go to DONE; otherwise `idx++`.
  - Strobes stay asserted across cache-miss stall cycles with address and data stable.
- **DONE**: `dHit=1` for exactly one cycle, strobes low, requests ignored; go to IDLE.
- **HALT**: `chalt=1`, strobes low, terminal until reset.
- `dhalt` raised during ACCESS is deferred; the current request completes first.
- Input address and data changes after acceptance have no effect; only the latched copies are used.
- `vdload` and `sdload` hold their values until overwritten by a later load. Stores never modify them.
- The `idx` counter is log2(THREADS) bits wide; the last access is `idx==THREADS-1`. No wrap occurs because the FSM leaves ACCESS at that point.

## Timing

- Reset values:
  - state IDLE, `idx=0`;
  - `dHit`, `dmemREN`, `dmemWEN`, `chalt` = 0;
  - `dmemaddr`, `dmemstore` = 0;
  - all `vdload` lanes and `sdload` = 0.
- Reset mid-ACCESS aborts immediately; strobes drop asynchronously.
- The request is accepted on the rising edge in IDLE (cycle 0), and strobes appear in cycle 1.
- Scalar latency with zero-wait cache: `dHit` in cycle 2.
- Vector latency with zero-wait cache: `dHit` in cycle THREADS+1.
- Each cache stall cycle adds one cycle.
- The earliest next acceptance is the cycle after `dHit`. The datapath must drop or change its request on that edge, or it is re-accepted.
- `dmemaddr`, `dmemstore`, and the strobes are registered or decoded from registered state only; there is no combinational path from `readReq`/`writeReq`.

## Configuration

- Macro: `VMS_LANE_MASK_EN`.
- **Defined**
  - Adds input port `vmask` (THREADS bits), latched with the request.
  - Lanes with a 0 mask bit are skipped with zero cycles and no strobe, and their `vdload` entries are unchanged.
  - `idx` advances to the next set bit.
  - An all-zero mask on a vector request goes IDLE→DONE directly, so `dHit` appears in cycle 1.
  - Scalar requests ignore `vmask`.
- **Undefined**: no `vmask` port; every lane is accessed.

## Test plan

- Scalar load:
  - stimulus: `sdaddr=0x40`, cache returns `0xDEADBEEF` with `dcacheHit` in cycle 1;
  - response: `dmemREN=1` with `dmemaddr=0x40` in cycle 1, `sdload=0xDEADBEEF` and `dHit` in cycle 2.
- Vector store:
  - stimulus: THREADS=4, addresses `0x100`/`0x104`/`0x108`/`0x10C`, data 1..4;
  - response: four consecutive `dmemWEN` cycles in lane order, `dHit` in cycle 5, `vdload` unchanged.
- Vector load with 2-cycle miss on lane 2:
  - response: `dmemaddr` held on lane 2's address for 3 cycles, `dHit` in cycle 7, each `vdload[i]` equals the data returned for lane i.
- Address change after acceptance:
  - stimulus: `vdaddr` altered in cycle 2 of a vector load;
  - response: the emitted addresses still match the values captured at cycle 0.
- Halt handling:
  - stimulus: `dhalt` raised mid-vector;
  - response: the request completes with `dHit`, then `chalt=1` from the following cycle and stays high; `RST` clears it to 0.
- With `VMS_LANE_MASK_EN` defined:
  - `vmask=4'b1010` gives accesses to lanes 1 and 3 only and `dHit` in cycle 3;
  - `vmask=0` gives `dHit` in cycle 1.
